qif_neuron_array: RTL and testbench

- Parametrised, multi-channel successor to the single quadratic integrate-and-fire neuron.
- N_CH neurons share one time-multiplexed QIF arithmetic datapath. A round-robin pointer updates one channel per enabled clock.
- Adds features the single neuron does not have: configurable width and threshold, saturating signed arithmetic, per-channel refractory period, spike pulses and a frame-done strobe.
- Sits between the synaptic-current front end and the spike router.

---
 rtl/qif_neuron_array.sv | 115 +++++++++++
 tb/tb_qif_neuron_array.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons sharing one saturating datapath.
// Optional leak term enabled by defining QIF_LEAK_EN.
module qif_neuron_array #(
  parameter int WIDTH      = 8,
  parameter int N_CH       = 4,
  parameter int V_RESET    = -20,
  parameter int V_TH       = 50,
  parameter int REFRAC     = 3,
  parameter int SQ_SHIFT   = 3,
  parameter int I_SHIFT    = 2,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        en,
  input  logic [N_CH*WIDTH-1:0]                       I_syn,
  output logic [N_CH*WIDTH-1:0]                       V_mem,
  output logic [N_CH-1:0]                             spike,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  ch_idx,
  output logic                                        frame_done
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int SW = 2*WIDTH + 2;

`ifdef QIF_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  localparam logic signed [WIDTH-1:0] VRST    = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] VTH     = WIDTH'(V_TH);
  localparam logic signed [SW-1:0]    SUM_MAX = SW'(2**(WIDTH-1) - 1);
  localparam logic signed [SW-1:0]    SUM_MIN = SW'(-(2**(WIDTH-1)));

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SUM_MAX)      sat = SUM_MAX[WIDTH-1:0];
    else if (x < SUM_MIN) sat = SUM_MIN[WIDTH-1:0];
    else                  sat = x[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] v_q [N_CH];
  logic [RW-1:0]           rf_q [N_CH];
  logic [CW-1:0]           ptr_q, ptr_d;
  logic [N_CH-1:0]         spike_q, spike_d;
  logic                    frame_q, frame_d;

  logic signed [WIDTH-1:0] v_cur, i_cur, vs, is_t, lk, v_d;
  logic [RW-1:0]           rf_cur, rf_d;
  logic signed [SW-1:0]    lk_term, sum;
  logic                    fire;

  // Shared datapath: evaluate the channel under the pointer
  always_comb begin
    v_cur   = v_q[ptr_q];
    rf_cur  = rf_q[ptr_q];
    i_cur   = I_syn[ptr_q*WIDTH +: WIDTH];
    vs      = v_cur >>> SQ_SHIFT;
    is_t    = i_cur >>> I_SHIFT;
    lk      = v_cur >>> LEAK_SHIFT;
    lk_term = SW'(0);
    if (LEAK_ON) lk_term = SW'(lk);
    sum     = SW'(v_cur) + SW'(vs) * SW'(vs) + SW'(is_t) - lk_term;

    fire = 1'b0;
    v_d  = v_cur;
    rf_d = rf_cur;
    if (rf_cur != '0) begin
      v_d  = VRST;
      rf_d = rf_cur - RW'(1);
    end else if (v_cur >= VTH) begin
      v_d  = VRST;
      rf_d = RW'(REFRAC);
      fire = 1'b1;
    end else begin
      v_d  = sat(sum);
    end

    for (int k = 0; k < N_CH; k++) spike_d[k] = fire && (ptr_q == CW'(k));
    frame_d = (ptr_q == CW'(N_CH-1));
    ptr_d   = (ptr_q == CW'(N_CH-1)) ? '0 : ptr_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        v_q[k]  <= VRST;
        rf_q[k] <= '0;
      end
      ptr_q   <= '0;
      spike_q <= '0;
      frame_q <= 1'b0;
    end else if (en) begin
      v_q[ptr_q]  <= v_d;
      rf_q[ptr_q] <= rf_d;
      ptr_q       <= ptr_d;
      spike_q     <= spike_d;
      frame_q     <= frame_d;
    end else begin
      spike_q <= '0;
      frame_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_vout
    assign V_mem[k*WIDTH +: WIDTH] = v_q[k];
  end

  assign spike      = spike_q;
  assign ch_idx     = ptr_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Scoreboarded bench for qif_neuron_array: default instance plus a V_TH=127 instance for saturation.
module tb_qif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [31:0] I_syn;
  logic [31:0] v0, v1;
  logic [3:0]  sp0, sp1;
  logic [1:0]  idx0, idx1;
  logic        fd0, fd1;

  qif_neuron_array u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .I_syn(I_syn),
    .V_mem(v0), .spike(sp0), .ch_idx(idx0), .frame_done(fd0)
  );

  qif_neuron_array #(.V_TH(127)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .I_syn(I_syn),
    .V_mem(v1), .spike(sp1), .ch_idx(idx1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v0, v1;
    logic [3:0]  s0, s1;
    logic        fd;
    logic [1:0]  idx;
  } exp_t;

  exp_t q[$];
  int   checks, errors;
  int   mv[2][4];
  int   mr[2][4];
  int   ptr;
  int   vth_m[2] = '{50, 127};

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -(((-a) + d - 1) / d);
  endfunction

  function automatic int clamp8(input int a);
    if (a > 127)  return 127;
    if (a < -128) return -128;
    return a;
  endfunction

  function automatic logic [31:0] pack(input int d);
    logic [31:0] r;
    int t;
    for (int k = 0; k < 4; k++) begin
      t = mv[d][k];
      r[k*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        mv[d][k] = -20;
        mr[d][k] = 0;
      end
    ptr = 0;
  endtask

  task automatic step(input bit e, input logic [31:0] cur);
    exp_t x;
    int c, iv, vs;
    logic [7:0] ib;
    @(negedge clk);
    en = e;
    I_syn = cur;
    x.s0 = '0;
    x.s1 = '0;
    x.fd = 1'b0;
    if (e) begin
      c  = ptr;
      ib = cur[c*8 +: 8];
      iv = $signed(ib);
      for (int d = 0; d < 2; d++) begin
        if (mr[d][c] != 0) begin
          mv[d][c] = -20;
          mr[d][c] = mr[d][c] - 1;
        end else if (mv[d][c] >= vth_m[d]) begin
          mv[d][c] = -20;
          mr[d][c] = 3;
          if (d == 0) x.s0[c] = 1'b1;
          else        x.s1[c] = 1'b1;
        end else begin
          vs = fdiv(mv[d][c], 8);
          mv[d][c] = clamp8(mv[d][c] + vs*vs + fdiv(iv, 4));
        end
      end
      x.fd = (c == 3);
      ptr  = (c + 1) % 4;
    end
    x.v0  = pack(0);
    x.v1  = pack(1);
    x.idx = ptr[1:0];
    q.push_back(x);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    en    = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_vmem_def", v0, 32'hECECECEC);
    check("rst_vmem_sat", v1, 32'hECECECEC);
    check("rst_spike", {24'h0, sp1, sp0}, 32'h0);
    check("rst_frame", {30'h0, fd1, fd0}, 32'h0);
    check("rst_idx", {28'h0, idx1, idx0}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Monitor: every enabled or idle cycle the driver queued produces one registered result
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      check("vmem_def", v0, x.v0);
      check("vmem_sat", v1, x.v1);
      check("spike_def", {28'h0, sp0}, {28'h0, x.s0});
      check("spike_sat", {28'h0, sp1}, {28'h0, x.s1});
      check("frame_done", {30'h0, fd1, fd0}, {30'h0, x.fd, x.fd});
      check("ch_idx", {28'h0, idx1, idx0}, {28'h0, x.idx, x.idx});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    I_syn  = '0;
    model_reset();
    async_reset();

    // Firing on ch0 with I=40, subthreshold drift on the others
    repeat (48) step(1'b1, 32'h00000028);
    @(posedge clk); #2;
    check("fire_ch0_after12", {24'h0, v0[7:0]}, 32'h15);
    check("subthr_ch1_zero", {24'h0, v0[15:8]}, 32'h0);

    // Enable gating with the pointer parked on channel 2
    repeat (2) step(1'b1, 32'h00000028);
    repeat (10) step(1'b0, $urandom);
    @(posedge clk); #2;
    check("gate_idx_hold", {30'h0, idx0}, 32'h2);
    repeat (8) step(1'b1, $urandom);

    // Saturation on the V_TH=127 instance
    async_reset();
    repeat (16) step(1'b1, 32'h0000007F);
    @(posedge clk); #2;
    check("sat_clamp_127", {24'h0, v1[7:0]}, 32'h7F);
    repeat (4) step(1'b1, 32'h0000007F);
    @(posedge clk); #2;
    check("sat_spike_reset", {24'h0, v1[7:0]}, 32'hEC);

    // Reset one update after a ch0 spike must clear refractory
    async_reset();
    repeat (25) step(1'b1, 32'h00000028);
    async_reset();
    step(1'b1, 32'h00000028);
    @(posedge clk); #2;
    check("refrac_cleared", {24'h0, v0[7:0]}, 32'hFF);

    // Randomised traffic with occasional resets
    for (int r = 0; r < 3; r++) begin
      async_reset();
      repeat (200) step($urandom_range(0, 3) != 0, $urandom);
    end

    @(posedge clk); #3;
    check("sb_drain", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
